// File: rtl/tx_beam_sequencer.sv
// Multi-element transmit beam sequencer: per-element delay table, square-wave bursts, N firings per scanline.
// Optional macro TX_BIPOLAR_EN adds txArrayN, the low-half drive for tri-level pulsers.
module tx_beam_sequencer #(
  parameter int NUM_ELEMENTS = 64,
  parameter int DW_DELAY     = 10,
  parameter int DW_HALF      = 4,
  parameter int DW_CYCLES    = 4,
  parameter int DW_POINTS    = 13,
  parameter int DW_PRI       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [$clog2(NUM_ELEMENTS)-1:0] cfg_addr,
  input  logic [DW_DELAY-1:0]             cfg_delay,
  input  logic [NUM_ELEMENTS-1:0]         element_en,
  input  logic [DW_HALF-1:0]              half_period,
  input  logic [DW_CYCLES-1:0]            num_cycles,
  input  logic [DW_POINTS-1:0]            num_points,
  input  logic [DW_PRI-1:0]               pri,
  input  logic                            initiate,
  input  logic                            abort,
  output logic [NUM_ELEMENTS-1:0]         txArray,
`ifdef TX_BIPOLAR_EN
  output logic [NUM_ELEMENTS-1:0]         txArrayN,
`endif
  output logic                            busy,
  output logic [DW_POINTS-1:0]            point_idx,
  output logic                            point_done,
  output logic                            done
);

  // state  | meaning
  // S_IDLE | waiting for initiate, delay table writable
  // S_FIRE | one PRI in progress, r_t counts 0..P'-1
  // S_END  | one-cycle done pulse, then back to S_IDLE
  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_END} state_t;

  localparam int TW  = DW_DELAY + DW_HALF + DW_CYCLES + 2;
  localparam int CW  = (TW > DW_PRI) ? TW : DW_PRI;
  localparam int HVW = DW_CYCLES + 1;

  state_t                 r_state, w_state_next;
  logic [DW_PRI-1:0]      r_t, w_t_next;
  logic [DW_POINTS-1:0]   r_point_idx, w_idx_next;
  logic                   w_start, w_latch, w_busy, w_fire_next;

  logic [NUM_ELEMENTS-1:0] r_en;
  logic [DW_HALF-1:0]      r_h;
  logic [DW_CYCLES-1:0]    r_c;
  logic [DW_POINTS-1:0]    r_n;
  logic [DW_PRI-1:0]       r_p;
  logic [DW_DELAY-1:0]     r_delay [NUM_ELEMENTS];

  logic [NUM_ELEMENTS-1:0] w_en_use;
  logic [DW_HALF-1:0]      w_h_in;
  logic [DW_CYCLES-1:0]    w_c_use;
  logic [DW_PRI-1:0]       w_p_in;

  logic [NUM_ELEMENTS-1:0]              r_act, w_act_next;
  logic [NUM_ELEMENTS-1:0][DW_HALF-1:0] r_ph, w_ph_next;
  logic [NUM_ELEMENTS-1:0][HVW-1:0]     r_hv, w_hv_next;
  logic [NUM_ELEMENTS-1:0]              r_tx, w_tx_next, w_txn_next;

  assign w_h_in   = (half_period == '0) ? DW_HALF'(1) : half_period;
  assign w_p_in   = (pri == '0) ? DW_PRI'(1) : pri;
  assign w_en_use = w_latch ? element_en : r_en;
  assign w_c_use  = w_latch ? num_cycles : r_c;

  always_comb begin
    w_state_next = r_state;
    w_t_next     = r_t;
    w_idx_next   = r_point_idx;
    w_start      = 1'b0;
    w_latch      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (initiate) begin
          w_latch = 1'b1;
          if (num_points != '0) begin
            w_state_next = S_FIRE;
            w_t_next     = '0;
            w_idx_next   = '0;
            w_start      = 1'b1;
          end else begin
            w_state_next = S_END;
          end
        end
      end
      S_FIRE: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (r_t == r_p - 1'b1) begin
          if (r_point_idx == r_n - 1'b1) begin
            w_state_next = S_END;
          end else begin
            w_idx_next = r_point_idx + 1'b1;
            w_t_next   = '0;
            w_start    = 1'b1;
          end
        end else begin
          w_t_next = r_t + 1'b1;
        end
      end
      S_END:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_fire_next = (w_state_next == S_FIRE);

  // Each element runs its own half-period phase counter so no divider is needed on the burst offset.
  always_comb begin
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      w_act_next[i] = 1'b0;
      w_ph_next[i]  = r_ph[i];
      w_hv_next[i]  = r_hv[i];
      if (w_fire_next) begin
        if ((CW'(w_t_next) == CW'(r_delay[i])) && (w_c_use != '0) && w_en_use[i]) begin
          w_act_next[i] = 1'b1;
          w_ph_next[i]  = '0;
          w_hv_next[i]  = '0;
        end else if (r_act[i] && !w_start) begin
          w_act_next[i] = 1'b1;
          if (r_ph[i] == r_h - 1'b1) begin
            w_ph_next[i] = '0;
            w_hv_next[i] = r_hv[i] + HVW'(1);
            if ((r_hv[i] + HVW'(1)) == {r_c, 1'b0}) w_act_next[i] = 1'b0;
          end else begin
            w_ph_next[i] = r_ph[i] + 1'b1;
          end
        end
      end
      w_tx_next[i]  = w_act_next[i] & ~w_hv_next[i][0];
      w_txn_next[i] = w_act_next[i] &  w_hv_next[i][0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_t         <= '0;
      r_point_idx <= '0;
      r_en        <= '0;
      r_h         <= DW_HALF'(1);
      r_c         <= '0;
      r_n         <= '0;
      r_p         <= DW_PRI'(1);
      r_act       <= '0;
      r_ph        <= '0;
      r_hv        <= '0;
      r_tx        <= '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) r_delay[i] <= '0;
    end else begin
      r_state     <= w_state_next;
      r_t         <= w_t_next;
      r_point_idx <= w_idx_next;
      if (w_latch) begin
        r_en <= element_en;
        r_h  <= w_h_in;
        r_c  <= num_cycles;
        r_n  <= num_points;
        r_p  <= w_p_in;
      end
      if (cfg_valid && cfg_ready && (int'(cfg_addr) < NUM_ELEMENTS))
        r_delay[cfg_addr] <= cfg_delay;
      r_act <= w_act_next;
      r_ph  <= w_ph_next;
      r_hv  <= w_hv_next;
      r_tx  <= w_tx_next;
    end
  end

`ifdef TX_BIPOLAR_EN
  logic [NUM_ELEMENTS-1:0] r_txn;
  always_ff @(posedge clk) begin
    if (rst) r_txn <= '0;
    else     r_txn <= w_txn_next;
  end
  assign txArrayN = r_txn;
`else
  // Unipolar build: the low half of each pulse cycle simply leaves the line idle.
`endif

  assign w_busy     = (r_state != S_IDLE);
  assign busy       = w_busy;
  assign cfg_ready  = !w_busy;
  assign txArray    = r_tx;
  assign point_idx  = r_point_idx;
  assign point_done = (r_state == S_FIRE) && (r_t == r_p - 1'b1) && !abort;
  assign done       = (r_state == S_END) && !abort;

endmodule

// File: tb/tb_tx_beam_sequencer.sv
// Directed bench for tx_beam_sequencer; per-cycle outputs are packed into bit vectors indexed by cycle after initiate.
module tb_tx_beam_sequencer;

  logic        clk = 1'b0;
  logic        rst, cfg_valid, cfg_ready, initiate, abort;
  logic [5:0]  cfg_addr;
  logic [9:0]  cfg_delay;
  logic [63:0] element_en, txArray;
  logic [3:0]  half_period, num_cycles;
  logic [12:0] num_points, point_idx;
  logic [15:0] pri;
  logic        busy, point_done, done;
`ifdef TX_BIPOLAR_EN
  logic [63:0] txArrayN;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int abort_at, reinit_at, wr_at;
  logic [63:0] v0, v1, v5, vn0, pd, dn, bs, rdy, acc, iv, ovl;

  always #5 clk = ~clk;

  tx_beam_sequencer dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_delay(cfg_delay), .element_en(element_en),
    .half_period(half_period), .num_cycles(num_cycles), .num_points(num_points),
    .pri(pri), .initiate(initiate), .abort(abort), .txArray(txArray),
`ifdef TX_BIPOLAR_EN
    .txArrayN(txArrayN),
`endif
    .busy(busy), .point_idx(point_idx), .point_done(point_done), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int dly);
    cyc();
    cfg_valid = 1'b1;
    cfg_addr  = 6'(addr);
    cfg_delay = 10'(dly);
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic setup(input logic [63:0] en, input int h, input int c, input int n, input int p);
    element_en  = en;
    half_period = 4'(h);
    num_cycles  = 4'(c);
    num_points  = 13'(n);
    pri         = 16'(p);
    abort_at    = -1;
    reinit_at   = -1;
    wr_at       = -1;
  endtask

  // Cycle 0 carries initiate; bit c of each vector is the output seen in cycle c.
  task automatic run_burst(input int ncyc);
    v0 = '0; v1 = '0; v5 = '0; vn0 = '0; pd = '0; dn = '0; bs = '0; rdy = '0; acc = '0; iv = '0;
    cyc();
    initiate = 1'b1;
    abort    = (abort_at == 0);
    @(negedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      cyc();
      initiate  = (c == reinit_at);
      abort     = (c == abort_at);
      cfg_valid = (c == wr_at);
      cfg_addr  = 6'd5;
      cfg_delay = 10'd7;
      @(negedge clk);
      v0[c]  = txArray[0];
      v1[c]  = txArray[1];
      v5[c]  = txArray[5];
      pd[c]  = point_done;
      dn[c]  = done;
      bs[c]  = busy;
      rdy[c] = cfg_ready;
      acc    = acc | txArray;
      if (c == 5 || c == 15 || c == 25) iv = (iv << 16) | 64'(point_idx);
`ifdef TX_BIPOLAR_EN
      vn0[c] = txArrayN[0];
      ovl    = ovl | (txArray & txArrayN);
`endif
    end
    initiate  = 1'b0;
    abort     = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_delay = '0; initiate = 1'b0; abort = 1'b0;
    ovl = '0;
    setup(64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 1, 20);
    cyc(); cyc();
    @(negedge clk);
    chk("rst_tx", txArray, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'h1);
    chk("rst_point_idx", 64'(point_idx), 64'h0);
    chk("rst_point_done", 64'(point_done), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    cyc();
    rst = 1'b0;

    wr(0, 0);
    wr(5, 3);

    // single point, two-cycle bursts
    setup(64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 1, 20);
    run_burst(22);
    chk("t1_el0", v0, 64'h66);
    chk("t1_el1", v1, 64'h66);
    chk("t1_el5", v5, 64'h330);
    chk("t1_point_done", pd, 64'h0010_0000);
    chk("t1_done", dn, 64'h0020_0000);
    chk("t1_busy", bs, 64'h003F_FFFE);
`ifdef TX_BIPOLAR_EN
    chk("t1_el0_n", vn0, 64'h198);
`endif

    // three points; re-initiate and table write while busy must be ignored
    setup(64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 3, 10);
    reinit_at = 12;
    wr_at     = 13;
    run_burst(33);
    chk("t2_el0", v0, 64'h0661_9866);
    chk("t2_el5", v5, 64'h330C_C330);
    chk("t2_point_done", pd, 64'h4010_0400);
    chk("t2_done", dn, 64'h8000_0000);
    chk("t2_point_idx", iv, 64'h0000_0000_0001_0002);
    chk("t2_cfg_ready", rdy, 64'h3_0000_0000);

    wr(1, 2);

    // aperture mask 0x0F with H=0 acting as H=1
    setup(64'h0F, 0, 1, 1, 8);
    run_burst(10);
    chk("t3_aperture", acc, 64'hF);
    chk("t3_el0", v0, 64'h2);
    chk("t3_el1", v1, 64'h8);
    chk("t3_point_done", pd, 64'h100);
    chk("t3_done", dn, 64'h200);

    // element 5 still uses delay 3 after the rejected write
    setup(64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 8);
    run_burst(10);
    chk("t4_el5_locked", v5, 64'h10);
    chk("t4_el0", v0, 64'h2);

    // C=0: no pulses, normal timing
    setup(64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 1, 6);
    run_burst(8);
    chk("t5_no_pulse", acc, 64'h0);
    chk("t5_point_done", pd, 64'h40);
    chk("t5_done", dn, 64'h80);

    // N=0: done one cycle after initiate
    setup(64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 0, 10);
    run_burst(3);
    chk("t6_done", dn, 64'h2);
    chk("t6_busy", bs, 64'h2);
    chk("t6_tx", acc, 64'h0);

    // abort at t=4 of point 1
    setup(64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 3, 10);
    abort_at = 15;
    run_burst(40);
    chk("t7_el0", v0, 64'h9866);
    chk("t7_busy", bs, 64'hFFFE);
    chk("t7_point_done", pd, 64'h400);
    chk("t7_done", dn, 64'h0);
    chk("t7_cfg_ready", rdy, 64'h1FF_FFFF_0000);

    // truncation: P=4, d=3, H=2
    setup(64'h20, 2, 2, 1, 4);
    run_burst(6);
    chk("t8_el5", v5, 64'h10);
    chk("t8_aperture", acc, 64'h20);
    chk("t8_point_done", pd, 64'h10);
    chk("t8_done", dn, 64'h20);

    // initiate and abort together in IDLE: initiate wins
    setup(64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 1, 5);
    abort_at = 0;
    run_burst(8);
    chk("t9_busy", bs, 64'h7E);
    chk("t9_done", dn, 64'h40);

`ifdef TX_BIPOLAR_EN
    chk("bipolar_overlap", ovl, 64'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
